fpu_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one multi-cycle, single-outstanding FPU datapath between `NUM_REQ` requesters, for example an integer core issue port and a vector/debug port. It accepts one request at a time, issues it to the FPU, waits for the result and routes the result and status back to the owning requester. It sits between the requesters' FP issue logic and the FPU top, and handles flush and an optional watchdog.

---
 rtl/fpu_share_arbiter.sv | 256 +++++++++++++++++++++++++
 tb/tb_fpu_share_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_share_arbiter.sv
// ----------------------------------------------------------------------------
// fpu_share_arbiter
//
// Shares one multi-cycle, single-outstanding FPU datapath between NUM_REQ
// requesters. One request is accepted at a time with round-robin priority,
// issued to the FPU, and its result and status are routed back to the
// requester that owns it. A flush abandons the current operation. If the FPU
// has already accepted the issue, the flush moves to DRAIN so that the
// orphaned result is still consumed.
//
// Optional feature macro: FPU_ARB_WATCHDOG_EN
//   When defined, a 10-bit watchdog bounds the time spent in WAIT and DRAIN.
//   - On expiry in WAIT, the arbiter answers the owner with a canonical NaN
//     and the NV flag set.
//   - On expiry in DRAIN, it returns to IDLE.
//   - timeout_o pulses for one cycle when the watchdog fires.
//   When the macro is undefined, no counter exists and timeout_o is 0.
//
// Parameters:
//   NUM_REQ        number of requesters (2..8)
//   WIDTH          operand / result width
//   TAG_WIDTH      per-request tag width, returned unchanged
//   TIMEOUT_CYCLES watchdog limit (1..1023), only meaningful with the macro
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               abandon the current operation
//   req_valid_i/ready_o   request handshake, one bit per requester
//   req_operands_i        requester r, operand k at [(r*3+k)*WIDTH +: WIDTH]
//   req_op_i/rnd_i/tag_i  requester r field at [r*5 +: 5], [r*3 +: 3],
//                         [r*TAG_WIDTH +: TAG_WIDTH]
//   fpu_valid_o/ready_i   issue handshake towards the FPU
//   fpu_operands_o        opa/opb/opc at [k*WIDTH +: WIDTH], registered
//   fpu_op_o, fpu_rnd_o   registered op code and rounding mode
//   fpu_out_valid_i/ready_o, fpu_result_i, fpu_status_i
//                         result handshake from the FPU
//   rsp_valid_o/ready_i   response handshake, owner bit only
//   rsp_result_o/status_o/tag_o
//                         shared response payload
//   busy_o                high whenever the FSM is not IDLE
//   timeout_o             one-cycle watchdog pulse
// ----------------------------------------------------------------------------
module fpu_share_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int WIDTH          = 64,
    parameter int TAG_WIDTH      = 5,
    parameter int TIMEOUT_CYCLES = 127
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,

    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*3*WIDTH-1:0]     req_operands_i,
    input  logic [NUM_REQ*5-1:0]           req_op_i,
    input  logic [NUM_REQ*3-1:0]           req_rnd_i,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag_i,

    output logic                           fpu_valid_o,
    input  logic                           fpu_ready_i,
    output logic [3*WIDTH-1:0]             fpu_operands_o,
    output logic [4:0]                     fpu_op_o,
    output logic [2:0]                     fpu_rnd_o,

    input  logic                           fpu_out_valid_i,
    output logic                           fpu_out_ready_o,
    input  logic [WIDTH-1:0]               fpu_result_i,
    input  logic [4:0]                     fpu_status_i,

    output logic [NUM_REQ-1:0]             rsp_valid_o,
    input  logic [NUM_REQ-1:0]             rsp_ready_i,
    output logic [WIDTH-1:0]               rsp_result_o,
    output logic [4:0]                     rsp_status_o,
    output logic [TAG_WIDTH-1:0]           rsp_tag_o,

    output logic                           busy_o,
    output logic                           timeout_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   next_ptr;

    logic               grant_found;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W:0]     cand_sum;
    logic [IDX_W-1:0]   cand_idx;

`ifdef FPU_ARB_WATCHDOG_EN
    // The watchdog fires on the cycle in which the count would reach the limit.
    localparam logic [9:0]       WD_LAST   = 10'(TIMEOUT_CYCLES - 1);
    localparam logic [WIDTH-1:0] CANON_NAN = WIDTH'(64'h7FF8_0000_0000_0000);
    logic [9:0]                  wd_count;
`endif

    // Round-robin winner: the first valid requester found scanning upward from
    // rr_ptr. The extra bit in cand_sum keeps the wrap free of overflow.
    always_comb begin
        grant_found = 1'b0;
        winner      = '0;
        cand_sum    = '0;
        cand_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (cand_sum >= (IDX_W+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
            end
            cand_idx = cand_sum[IDX_W-1:0];
            if (!grant_found && req_valid_i[cand_idx]) begin
                grant_found = 1'b1;
                winner      = cand_idx;
            end
        end
    end

    // The grant is combinational so a requester sees acceptance in the same
    // cycle it presents the request. Flush and reset suppress it.
    always_comb begin
        req_ready_o = '0;
        if (state == S_IDLE && !rst_i && !flush_i && grant_found) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    // Only the owner ever sees a response valid.
    always_comb begin
        rsp_valid_o = '0;
        if (state == S_RESP) begin
            rsp_valid_o[owner] = 1'b1;
        end
    end

    assign fpu_valid_o     = (state == S_ISSUE);
    assign fpu_out_ready_o = (state == S_WAIT) || (state == S_DRAIN);
    assign busy_o          = (state != S_IDLE);
    assign next_ptr        = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

`ifndef FPU_ARB_WATCHDOG_EN
    // TIMEOUT_CYCLES is at least 1, so this is a constant 0. Referencing the
    // parameter keeps it live in builds without the watchdog.
    assign timeout_o = (TIMEOUT_CYCLES == 0);
`endif

    // Main sequencer. Flush is checked first in every state that honours it, so
    // it overrides any handshake completing in the same cycle. A flush in WAIT
    // goes to DRAIN rather than IDLE because the FPU still owes a result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= S_IDLE;
            rr_ptr         <= '0;
            owner          <= '0;
            fpu_operands_o <= '0;
            fpu_op_o       <= '0;
            fpu_rnd_o      <= '0;
            rsp_result_o   <= '0;
            rsp_status_o   <= '0;
            rsp_tag_o      <= '0;
`ifdef FPU_ARB_WATCHDOG_EN
            wd_count       <= '0;
            timeout_o      <= 1'b0;
`endif
        end else begin
`ifdef FPU_ARB_WATCHDOG_EN
            timeout_o <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (!flush_i && grant_found) begin
                        fpu_operands_o <= req_operands_i[int'(winner)*3*WIDTH +: 3*WIDTH];
                        fpu_op_o       <= req_op_i[int'(winner)*5 +: 5];
                        fpu_rnd_o      <= req_rnd_i[int'(winner)*3 +: 3];
                        rsp_tag_o      <= req_tag_i[int'(winner)*TAG_WIDTH +: TAG_WIDTH];
                        owner          <= winner;
                        state          <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (flush_i) begin
                        state <= S_IDLE;
                    end else if (fpu_ready_i) begin
                        state <= S_WAIT;
`ifdef FPU_ARB_WATCHDOG_EN
                        wd_count <= '0;
`endif
                    end
                end

                S_WAIT: begin
                    if (flush_i) begin
                        state <= S_DRAIN;
`ifdef FPU_ARB_WATCHDOG_EN
                        wd_count <= '0;
`endif
                    end else if (fpu_out_valid_i) begin
                        rsp_result_o <= fpu_result_i;
                        rsp_status_o <= fpu_status_i;
                        state        <= S_RESP;
                    end
`ifdef FPU_ARB_WATCHDOG_EN
                    else if (wd_count == WD_LAST) begin
                        // Synthesise an invalid-operation answer so the owner
                        // is never left waiting on a hung FPU.
                        rsp_result_o <= CANON_NAN;
                        rsp_status_o <= 5'b10000;
                        timeout_o    <= 1'b1;
                        state        <= S_RESP;
                    end else begin
                        wd_count <= wd_count + 10'd1;
                    end
`endif
                end

                S_DRAIN: begin
                    if (fpu_out_valid_i) begin
                        state <= S_IDLE;
                    end
`ifdef FPU_ARB_WATCHDOG_EN
                    else if (wd_count == WD_LAST) begin
                        timeout_o <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        wd_count <= wd_count + 10'd1;
                    end
`endif
                end

                S_RESP: begin
                    if (flush_i) begin
                        state <= S_IDLE;
                    end else if (rsp_ready_i[owner]) begin
                        rr_ptr <= next_ptr;
                        state  <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fpu_share_arbiter
//
// Directed bench for fpu_share_arbiter with two 64-bit requesters.
// It covers the following cases:
//   - reset
//   - alternating round-robin grants
//   - issue back-pressure
//   - flush in IDLE, ISSUE and WAIT (including DRAIN)
//   - response back-pressure with a competing request
//   - watchdog behaviour in either build
// Expected values come from the bench's own payload tables and constants.
// ----------------------------------------------------------------------------
module tb_fpu_share_arbiter;

    localparam int NUM_REQ        = 2;
    localparam int WIDTH          = 64;
    localparam int TAG_WIDTH      = 5;
    localparam int TIMEOUT_CYCLES = 10;

    logic                         clk_i = 1'b0;
    logic                         rst_i;
    logic                         flush_i;
    logic [NUM_REQ-1:0]           req_valid_i;
    logic [NUM_REQ-1:0]           req_ready_o;
    logic [NUM_REQ*3*WIDTH-1:0]   req_operands_i;
    logic [NUM_REQ*5-1:0]         req_op_i;
    logic [NUM_REQ*3-1:0]         req_rnd_i;
    logic [NUM_REQ*TAG_WIDTH-1:0] req_tag_i;
    logic                         fpu_valid_o;
    logic                         fpu_ready_i;
    logic [3*WIDTH-1:0]           fpu_operands_o;
    logic [4:0]                   fpu_op_o;
    logic [2:0]                   fpu_rnd_o;
    logic                         fpu_out_valid_i;
    logic                         fpu_out_ready_o;
    logic [WIDTH-1:0]             fpu_result_i;
    logic [4:0]                   fpu_status_i;
    logic [NUM_REQ-1:0]           rsp_valid_o;
    logic [NUM_REQ-1:0]           rsp_ready_i;
    logic [WIDTH-1:0]             rsp_result_o;
    logic [4:0]                   rsp_status_o;
    logic [TAG_WIDTH-1:0]         rsp_tag_o;
    logic                         busy_o;
    logic                         timeout_o;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] pay_opnd [2][3];
    logic [4:0]  pay_op   [2];
    logic [2:0]  pay_rnd  [2];
    logic [4:0]  pay_tag  [2];

    fpu_share_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .WIDTH          (WIDTH),
        .TAG_WIDTH      (TAG_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_operands_i  (req_operands_i),
        .req_op_i        (req_op_i),
        .req_rnd_i       (req_rnd_i),
        .req_tag_i       (req_tag_i),
        .fpu_valid_o     (fpu_valid_o),
        .fpu_ready_i     (fpu_ready_i),
        .fpu_operands_o  (fpu_operands_o),
        .fpu_op_o        (fpu_op_o),
        .fpu_rnd_o       (fpu_rnd_o),
        .fpu_out_valid_i (fpu_out_valid_i),
        .fpu_out_ready_o (fpu_out_ready_o),
        .fpu_result_i    (fpu_result_i),
        .fpu_status_i    (fpu_status_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_result_o    (rsp_result_o),
        .rsp_status_o    (rsp_status_o),
        .rsp_tag_o       (rsp_tag_o),
        .busy_o          (busy_o),
        .timeout_o       (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: observed no finish, expected finish before 100000");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic check_output(input string name, input logic [191:0] observed,
                                input logic [191:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are checked
    // before the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic apply_stimulus();
        for (int r = 0; r < NUM_REQ; r++) begin
            for (int k = 0; k < 3; k++) begin
                req_operands_i[(r*3+k)*WIDTH +: WIDTH] = pay_opnd[r][k];
            end
            req_op_i[r*5 +: 5]                 = pay_op[r];
            req_rnd_i[r*3 +: 3]                = pay_rnd[r];
            req_tag_i[r*TAG_WIDTH +: TAG_WIDTH] = pay_tag[r];
        end
    endtask

    function automatic logic [191:0] exp_operands(input int r);
        return {pay_opnd[r][2], pay_opnd[r][1], pay_opnd[r][0]};
    endfunction

    // One complete operation with no stalls. The FSM is in IDLE on entry and
    // the caller has already set req_valid_i.
    task automatic run_op(input int owner, input logic [63:0] result,
                          input logic [4:0] status, input string name);
        logic [1:0] oh;
        oh = 2'b01 << owner;
        settle();
        check_output({name, "_grant"}, req_ready_o, oh);
        tick();
        check_output({name, "_issue_valid"}, fpu_valid_o, 1'b1);
        check_output({name, "_issue_operands"}, fpu_operands_o, exp_operands(owner));
        check_output({name, "_issue_op"}, fpu_op_o, pay_op[owner]);
        check_output({name, "_issue_rnd"}, fpu_rnd_o, pay_rnd[owner]);
        check_output({name, "_no_grant_in_issue"}, req_ready_o, 2'b00);
        fpu_ready_i = 1'b1;
        tick();
        fpu_ready_i = 1'b0;
        check_output({name, "_wait_valid_low"}, fpu_valid_o, 1'b0);
        check_output({name, "_wait_out_ready"}, fpu_out_ready_o, 1'b1);
        fpu_out_valid_i = 1'b1;
        fpu_result_i    = result;
        fpu_status_i    = status;
        tick();
        fpu_out_valid_i = 1'b0;
        fpu_result_i    = 64'hDEAD_BEEF_DEAD_BEEF;
        fpu_status_i    = 5'b11111;
        settle();
        check_output({name, "_rsp_valid"}, rsp_valid_o, oh);
        check_output({name, "_rsp_result"}, rsp_result_o, result);
        check_output({name, "_rsp_status"}, rsp_status_o, status);
        check_output({name, "_rsp_tag"}, rsp_tag_o, pay_tag[owner]);
        check_output({name, "_rsp_out_ready_low"}, fpu_out_ready_o, 1'b0);
        check_output({name, "_rsp_timeout_low"}, timeout_o, 1'b0);
        rsp_ready_i = 2'b11;
        tick();
        rsp_ready_i = 2'b00;
        check_output({name, "_idle_busy"}, busy_o, 1'b0);
        check_output({name, "_idle_rsp_valid"}, rsp_valid_o, 2'b00);
    endtask

    initial begin
        pay_opnd[0][0] = 64'h3FF0_0000_0000_0000;
        pay_opnd[0][1] = 64'h4000_0000_0000_0000;
        pay_opnd[0][2] = 64'h0000_0000_0000_0000;
        pay_op[0]      = 5'd1;
        pay_rnd[0]     = 3'd0;
        pay_tag[0]     = 5'd3;
        pay_opnd[1][0] = 64'hC008_0000_0000_0000;
        pay_opnd[1][1] = 64'h3FE0_0000_0000_0000;
        pay_opnd[1][2] = 64'h0000_0000_0000_0001;
        pay_op[1]      = 5'd7;
        pay_rnd[1]     = 3'd2;
        pay_tag[1]     = 5'd17;

        rst_i           = 1'b1;
        flush_i         = 1'b0;
        req_valid_i     = 2'b11;
        fpu_ready_i     = 1'b0;
        fpu_out_valid_i = 1'b0;
        fpu_result_i    = '0;
        fpu_status_i    = '0;
        rsp_ready_i     = 2'b00;
        apply_stimulus();

        // Reset with both requesters valid.
        tick();
        tick();
        settle();
        check_output("reset_req_ready", req_ready_o, 2'b00);
        check_output("reset_fpu_valid", fpu_valid_o, 1'b0);
        check_output("reset_out_ready", fpu_out_ready_o, 1'b0);
        check_output("reset_busy", busy_o, 1'b0);
        check_output("reset_rsp_valid", rsp_valid_o, 2'b00);
        check_output("reset_timeout", timeout_o, 1'b0);
        check_output("reset_fpu_op", fpu_op_o, 5'd0);
        check_output("reset_rsp_tag", rsp_tag_o, 5'd0);
        rst_i = 1'b0;

        // Four back-to-back operations with both valid: grants 0,1,0,1.
        run_op(0, 64'h4000_0000_0000_0000, 5'b00000, "op0");
        run_op(1, 64'hC000_0000_0000_0000, 5'b00001, "op1");
        run_op(0, 64'h3FF8_0000_0000_0000, 5'b00100, "op2");
        run_op(1, 64'h7FF0_0000_0000_0000, 5'b00101, "op3");

        // Issue held off for 5 cycles while the requester's inputs change.
        req_valid_i = 2'b10;
        settle();
        check_output("stall_grant", req_ready_o, 2'b10);
        tick();
        req_valid_i    = 2'b00;
        req_operands_i = ~req_operands_i;
        req_op_i       = ~req_op_i;
        req_rnd_i      = ~req_rnd_i;
        for (int i = 0; i < 5; i++) begin
            check_output("stall_fpu_valid", fpu_valid_o, 1'b1);
            check_output("stall_operands", fpu_operands_o, exp_operands(1));
            check_output("stall_op", fpu_op_o, pay_op[1]);
            check_output("stall_rnd", fpu_rnd_o, pay_rnd[1]);
            tick();
        end
        fpu_ready_i = 1'b1;
        check_output("stall_still_valid", fpu_valid_o, 1'b1);
        tick();
        apply_stimulus();
        check_output("stall_accepted_valid_low", fpu_valid_o, 1'b0);
        check_output("stall_wait_out_ready", fpu_out_ready_o, 1'b1);
        tick();
        fpu_ready_i = 1'b0;
        check_output("stall_no_reissue", fpu_valid_o, 1'b0);
        fpu_out_valid_i = 1'b1;
        fpu_result_i    = 64'h4010_0000_0000_0000;
        fpu_status_i    = 5'b00000;
        tick();
        fpu_out_valid_i = 1'b0;
        check_output("stall_rsp_valid", rsp_valid_o, 2'b10);
        check_output("stall_rsp_tag", rsp_tag_o, pay_tag[1]);
        check_output("stall_rsp_result", rsp_result_o, 64'h4010_0000_0000_0000);
        rsp_ready_i = 2'b10;
        tick();
        rsp_ready_i = 2'b00;

        // Flush in WAIT, stray flush in DRAIN, result 3 cycles after the flush.
        req_valid_i = 2'b11;
        settle();
        check_output("flushw_grant", req_ready_o, 2'b01);
        tick();
        fpu_ready_i = 1'b1;
        tick();
        fpu_ready_i = 1'b0;
        flush_i     = 1'b1;
        tick();
        flush_i = 1'b0;
        settle();
        check_output("drain1_busy", busy_o, 1'b1);
        check_output("drain1_out_ready", fpu_out_ready_o, 1'b1);
        check_output("drain1_rsp_valid", rsp_valid_o, 2'b00);
        check_output("drain1_req_ready", req_ready_o, 2'b00);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check_output("drain2_busy", busy_o, 1'b1);
        check_output("drain2_out_ready", fpu_out_ready_o, 1'b1);
        fpu_out_valid_i = 1'b1;
        fpu_result_i    = 64'h1111_2222_3333_4444;
        tick();
        fpu_out_valid_i = 1'b0;
        check_output("drain_done_busy", busy_o, 1'b0);
        check_output("drain_done_rsp_valid", rsp_valid_o, 2'b00);
        check_output("drain_done_out_ready", fpu_out_ready_o, 1'b0);
        run_op(0, 64'h4014_0000_0000_0000, 5'b00010, "post_flush");

        // Flush in IDLE blocks the grant; flush in ISSUE keeps rr_ptr.
        flush_i = 1'b1;
        settle();
        check_output("flushi_no_grant", req_ready_o, 2'b00);
        tick();
        flush_i = 1'b0;
        check_output("flushi_still_idle", busy_o, 1'b0);
        settle();
        check_output("flushs_grant", req_ready_o, 2'b10);
        tick();
        check_output("flushs_issue", fpu_valid_o, 1'b1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check_output("flushs_idle", busy_o, 1'b0);
        check_output("flushs_valid_low", fpu_valid_o, 1'b0);
        run_op(1, 64'h4018_0000_0000_0000, 5'b01000, "post_issue_flush");

        // Response held for 4 cycles; the other requester competes and the
        // non-owner rsp_ready bit is high.
        req_valid_i = 2'b10;
        settle();
        check_output("rsps_grant", req_ready_o, 2'b10);
        tick();
        req_valid_i = 2'b00;
        fpu_ready_i = 1'b1;
        tick();
        fpu_ready_i     = 1'b0;
        fpu_out_valid_i = 1'b1;
        fpu_result_i    = 64'h0123_4567_89AB_CDEF;
        fpu_status_i    = 5'b00101;
        tick();
        fpu_out_valid_i = 1'b0;
        fpu_result_i    = '0;
        fpu_status_i    = '0;
        req_valid_i     = 2'b01;
        rsp_ready_i     = 2'b01;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_output("rsps_rsp_valid", rsp_valid_o, 2'b10);
            check_output("rsps_rsp_result", rsp_result_o, 64'h0123_4567_89AB_CDEF);
            check_output("rsps_rsp_status", rsp_status_o, 5'b00101);
            check_output("rsps_rsp_tag", rsp_tag_o, pay_tag[1]);
            check_output("rsps_no_grant", req_ready_o, 2'b00);
            tick();
        end
        rsp_ready_i = 2'b10;
        tick();
        rsp_ready_i = 2'b00;
        settle();
        check_output("rsps_done_busy", busy_o, 1'b0);
        check_output("rsps_done_rsp_valid", rsp_valid_o, 2'b00);
        run_op(0, 64'h401C_0000_0000_0000, 5'b00000, "after_rsp_stall");

        // Hung FPU: no result is ever returned.
        req_valid_i = 2'b01;
        settle();
        check_output("wd_grant", req_ready_o, 2'b01);
        tick();
        req_valid_i = 2'b00;
        fpu_ready_i = 1'b1;
        tick();
        fpu_ready_i = 1'b0;
`ifdef FPU_ARB_WATCHDOG_EN
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) begin
            tick();
            check_output("wd_wait_timeout_low", timeout_o, 1'b0);
            check_output("wd_wait_out_ready", fpu_out_ready_o, 1'b1);
        end
        tick();
        check_output("wd_timeout_pulse", timeout_o, 1'b1);
        check_output("wd_rsp_valid", rsp_valid_o, 2'b01);
        check_output("wd_rsp_result", rsp_result_o, 64'h7FF8_0000_0000_0000);
        check_output("wd_rsp_status", rsp_status_o, 5'b10000);
        check_output("wd_rsp_tag", rsp_tag_o, pay_tag[0]);
        tick();
        check_output("wd_timeout_single", timeout_o, 1'b0);
        check_output("wd_rsp_held", rsp_valid_o, 2'b01);
        rsp_ready_i = 2'b01;
        tick();
        rsp_ready_i = 2'b00;
        check_output("wd_idle", busy_o, 1'b0);
`else
        for (int i = 0; i < 2*TIMEOUT_CYCLES; i++) begin
            tick();
            check_output("nowd_timeout_low", timeout_o, 1'b0);
            check_output("nowd_still_wait", fpu_out_ready_o, 1'b1);
            check_output("nowd_no_rsp", rsp_valid_o, 2'b00);
        end
        fpu_out_valid_i = 1'b1;
        fpu_result_i    = 64'h4020_0000_0000_0000;
        fpu_status_i    = 5'b00001;
        tick();
        fpu_out_valid_i = 1'b0;
        check_output("nowd_rsp_valid", rsp_valid_o, 2'b01);
        check_output("nowd_rsp_result", rsp_result_o, 64'h4020_0000_0000_0000);
        rsp_ready_i = 2'b01;
        tick();
        rsp_ready_i = 2'b00;
        check_output("nowd_idle", busy_o, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
